lfsr_checker: RTL

Receive-side companion to the 4-bit LFSR generator. Samples the generator's parallel state word whenever enable is high, self-synchronises to the sequence, then predicts and compares each following word. Reports lock status, per-word error pulses and saturating error/word counters. Used in benches and on-chip loopback to qualify links carrying the LFSR pattern.

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_checker_sat_counter.sv | 33 +++
 rtl/lfsr_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM state encoding, default polynomial and the
// next-state function used by both the generator and the checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 4'b1100;

  // Widest LFSR the shared function supports; narrower ones are masked.
  localparam int unsigned MAX_W = 32;

  // Fibonacci shift-left: feedback is the XOR of tapped bits, entering at bit 0.
  function automatic logic [MAX_W-1:0] lfsr_next(
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] taps,
    input int unsigned      w = DEF_WIDTH
  );
    logic [MAX_W-1:0] mask;
    mask = ~({MAX_W{1'b1}} << w);
    return ((q << 1) | MAX_W'(^(q & taps))) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming word stream,
// then flywheels the prediction and reports lock, error pulses and counts.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     TAPS         = DEF_TAPS,
  parameter int unsigned          LOCK_COUNT   = 4,
  parameter int unsigned          UNLOCK_COUNT = 3,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned MATCH_W = (LOCK_COUNT   < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = (UNLOCK_COUNT < 1) ? 1 : $clog2(UNLOCK_COUNT + 1);

  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("LOCK_COUNT must be at least 1");
  end
  if (UNLOCK_COUNT < 1) begin : g_bad_unlock
    $error("UNLOCK_COUNT must be at least 1");
  end
  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("WIDTH out of supported range");
  end

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return WIDTH'(lfsr_next(MAX_W'(x), MAX_W'(TAPS), WIDTH));
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q,   exp_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q,  miss_d;
  logic               err_q,   err_d;
  logic               err_inc;
  logic               word_inc;
  logic               hit;
  logic               nonzero;

  assign hit     = (lfsr_in == exp_q);
  assign nonzero = (lfsr_in != '0);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    word_inc = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (nonzero) begin
            exp_d   = nxt(lfsr_in);
            match_d = '0;
            state_d = SYNC;
          end
        end

        SYNC: begin
          if (hit) begin
            exp_d   = nxt(lfsr_in);
            match_d = match_q + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (nonzero) begin
            exp_d   = nxt(lfsr_in);
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end

        LOCKED: begin
          // Flywheel: prediction never reseeds from the line, so a single
          // corrupted word costs exactly one error.
          exp_d    = nxt(exp_q);
          word_inc = 1'b1;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(UNLOCK_COUNT)) begin
              state_d = HUNT;
              miss_d  = '0;
              match_d = '0;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (word_inc),
    .clr_i (clr),
    .cnt_o (word_cnt)
  );

  assign locked = (state_q == LOCKED);
  assign err    = err_q;

endmodule
